// File: rtl/axi_lite_master_cmd.sv
// axi_lite_master_cmd: single-outstanding AXI-Lite master turning register commands into AXI-Lite transactions
module axi_lite_master_cmd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done, w_done;
  logic                cmd_fire, aw_fire, w_fire, b_fire, r_fire, rsp_fire;
  logic [1:0]          new_resp;
  assign cmd_fire = cmd_valid & cmd_ready;
  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;
  assign b_fire   = m_axi_bvalid & m_axi_bready;
  assign r_fire   = m_axi_rvalid & m_axi_rready;
  assign rsp_fire = rsp_valid & rsp_ready;
  assign new_resp = b_fire ? m_axi_bresp : m_axi_rresp;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = cmd_fire ? (cmd_write ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  nxt = ((aw_done | aw_fire) & (w_done | w_fire)) ? WR_RESP : WR_REQ;
      WR_RESP: nxt = b_fire ? RSP : WR_RESP;
      RD_REQ:  nxt = m_axi_arready ? RD_DATA : RD_REQ;
      RD_DATA: nxt = r_fire ? RSP : RD_DATA;
      RSP:     nxt = rsp_fire ? IDLE : RSP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready     = state == IDLE;
    busy          = state != IDLE;
    m_axi_awvalid = state == WR_REQ && !aw_done;
    m_axi_wvalid  = state == WR_REQ && !w_done;
    m_axi_bready  = state == WR_RESP;
    m_axi_arvalid = state == RD_REQ;
    m_axi_rready  = state == RD_DATA;
    rsp_valid     = state == RSP;
    m_axi_awaddr  = addr_q;
    m_axi_araddr  = addr_q;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = wstrb_q;
  end
  // Holding registers keep AW/W/AR payload stable for the whole transaction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_write <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      err_cnt   <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        rsp_write <= cmd_write;
      end
      aw_done <= cmd_fire ? 1'b0 : aw_done | aw_fire;
      w_done  <= cmd_fire ? 1'b0 : w_done | w_fire;
      if (b_fire | r_fire) begin
        rsp_rdata <= b_fire ? '0 : m_axi_rdata;
        rsp_resp  <= new_resp;
        if (new_resp[1] && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// tb_axi_lite_master_cmd: directed cycle-by-cycle bench acting as the AXI-Lite slave and command host
module tb_axi_lite_master_cmd;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [7:0]  err_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata = 0;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0]  bresp = 0, rresp = 0;
  int total = 0, bad = 0;

  axi_lite_master_cmd dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .err_cnt(err_cnt),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] br, input logic [7:0] exp_err);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    chk("wr_awvalid", awvalid, 1);
    tick();
    chk("wr_bready", bready, 1);
    bvalid = 1; bresp = br;
    tick();
    bvalid = 0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_resp", rsp_resp, br);
    chk("wr_err_cnt", err_cnt, exp_err);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr, input logic [7:0] exp_err, input bit consume);
    cmd_valid = 1; cmd_write = 0; cmd_addr = a;
    arready = 1;
    tick();
    cmd_valid = 0;
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, a);
    tick();
    chk("rd_rready", rready, 1);
    rvalid = 1; rdata = d; rresp = rr;
    tick();
    rvalid = 0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, d);
    chk("rd_rsp_resp", rsp_resp, rr);
    chk("rd_rsp_write", rsp_write, 0);
    chk("rd_err_cnt", err_cnt, exp_err);
    if (consume) begin
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_resp, rsp_rdata}, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // basic write, always-ready slave
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h08; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    chk("t1_aw_w_valid", {awvalid, wvalid}, 2'b11);
    chk("t1_awaddr", awaddr, 32'h08);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_wstrb", wstrb, 4'hF);
    chk("t1_busy", busy, 1);
    chk("t1_cmd_ready", cmd_ready, 0);
    tick();
    chk("t1_bready", bready, 1);
    chk("t1_valids_drop", {awvalid, wvalid}, 0);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
    chk("t1_err_cnt", err_cnt, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t1_idle", cmd_ready, 1);

    // awready delayed three cycles, wready immediate
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0C; cmd_wdata = 32'h12345678;
    awready = 0; wready = 1;
    tick();
    cmd_valid = 0;
    chk("t2_c1_valids", {awvalid, wvalid}, 2'b11);
    for (int i = 2; i <= 4; i++) begin
      if (i == 4) awready = 1;
      tick();
      chk("t2_wvalid_low", wvalid, 0);
      chk("t2_awvalid", awvalid, i < 4);
      chk("t2_awaddr", awaddr, 32'h0C);
      chk("t2_bready", bready, i == 4);
    end
    bvalid = 1; bresp = 2'b00;
    tick();
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_one_b", bready, 0);
    tick();
    bvalid = 0;
    chk("t2_rsp_hold", rsp_valid, 1);
    chk("t2_rsp_resp", rsp_resp, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // read with rvalid delayed five cycles
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
    arready = 1;
    tick();
    cmd_valid = 0;
    chk("t3_arvalid", arvalid, 1);
    chk("t3_araddr", araddr, 32'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_rready", rready, 1);
      chk("t3_arvalid_low", arvalid, 0);
    end
    rvalid = 1; rdata = 32'h40; rresp = 2'b00;
    tick();
    rvalid = 0;
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_rdata", rsp_rdata, 32'h40);
    chk("t3_rsp_write", rsp_write, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // error responses and counter saturation
    wr(32'h04, 32'h1, 2'b10, 8'd1);
    rd(32'h04, 32'hCAFE, 2'b11, 8'd2, 1);
    for (int i = 3; i <= 255; i++) wr(32'h04, i, 2'b10, i[7:0]);
    wr(32'h04, 32'h0, 2'b11, 8'd255);
    wr(32'h08, 32'h0, 2'b01, 8'd255);

    // response back-pressure
    rd(32'h14, 32'hA5A5_0001, 2'b00, 8'd255, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_rsp_valid", rsp_valid, 1);
      chk("t5_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("t5_cmd_ready", cmd_ready, 0);
      if (i == 2) begin cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; end
      if (i == 3) cmd_valid = 0;
      tick();
    end
    chk("t5_no_accept", {awvalid, wvalid, busy}, 3'b001);
    rsp_ready = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h24; cmd_wdata = 32'h77;
    tick();
    rsp_ready = 0;
    chk("t5_idle", cmd_ready, 1);
    chk("t5_not_same_cycle", awvalid, 0);
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    chk("t5_accept", awvalid, 1);
    chk("t5_awaddr", awaddr, 32'h24);
    tick();
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("t5_rsp_valid", rsp_valid, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // asynchronous reset during WR_REQ
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30;
    awready = 0; wready = 0;
    tick();
    cmd_valid = 0;
    chk("t6_awvalid", awvalid, 1);
    #2 rst = 1;
    #1;
    chk("t6_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_rsp", {rsp_resp, rsp_rdata}, 0);
    #2 rst = 0;
    tick();
    chk("t6_cmd_ready", cmd_ready, 1);
    rd(32'h10, 32'h0BAD_F00D, 2'b00, 8'd0, 1);
    chk("t6_final_idle", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
